// File: rtl/apu_audio_pkg.sv
// Shared audio constants for the APU channel blocks and the PWM output stage.
package apu_audio_pkg;

  localparam int AUDIO_SAMPLE_WIDTH = 9;

endpackage

// File: rtl/pwm_counter.sv
// Free-running PWM period counter and duty compare; flags the wrap cycle to the parent.
module pwm_counter
  import apu_audio_pkg::*;
#(
  parameter int WIDTH = AUDIO_SAMPLE_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_duty,
  output logic             o_wrap,
  output logic             o_period_stb,
  output logic             o_pwm
);

  logic [WIDTH-1:0] cnt_q;

  // High in the last cycle of a period: the next edge takes the counter to 0.
  assign o_wrap = (cnt_q == '1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q        <= '0;
      o_period_stb <= 1'b0;
      o_pwm        <= 1'b0;
    end else begin
      cnt_q        <= cnt_q + 1'b1;
      o_period_stb <= o_wrap;
      o_pwm        <= (cnt_q < i_duty);
    end
  end

endmodule

// File: rtl/apu_pwm_dac.sv
// APU PWM DAC: one-entry sample holder feeding a period-aligned duty register and PWM counter.
module apu_pwm_dac
  import apu_audio_pkg::*;
#(
  parameter int SAMPLE_WIDTH = AUDIO_SAMPLE_WIDTH
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [SAMPLE_WIDTH-1:0] i_sample,
  input  logic                    i_sample_valid,
  output logic                    o_sample_ready,
  output logic                    o_pwm,
  output logic                    o_period_stb,
  output logic                    o_underrun
);

  // Handshake: a sample transfers on a rising edge where i_sample_valid and
  // o_sample_ready are both high; o_sample_ready is a pure register output.
  logic [SAMPLE_WIDTH-1:0] hold_q;
  logic [SAMPLE_WIDTH-1:0] duty_q;
  logic                    full_q;
  logic                    full_d;
  logic                    ready_q;
  logic                    underrun_q;
  logic                    accept;
  logic                    wrap;

  assign accept = i_sample_valid & ready_q;

  // An acceptance on a wrap edge with an empty holder refills it after the wrap.
  always_comb begin
    full_d = full_q;
    if (wrap)   full_d = 1'b0;
    if (accept) full_d = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hold_q     <= '0;
      duty_q     <= '0;
      full_q     <= 1'b0;
      ready_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      if (accept)          hold_q <= i_sample;
      if (wrap && full_q)  duty_q <= hold_q;
      full_q     <= full_d;
      ready_q    <= ~full_d;
      underrun_q <= wrap & ~full_q;
    end
  end

  pwm_counter #(
    .WIDTH (SAMPLE_WIDTH)
  ) u_pwm_counter (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_duty       (duty_q),
    .o_wrap       (wrap),
    .o_period_stb (o_period_stb),
    .o_pwm        (o_pwm)
  );

  assign o_sample_ready = ready_q;
  assign o_underrun     = underrun_q;

endmodule

// File: doc/apu_pwm_dac.md
APU_PWM_DAC -- requirements
Module: apu_pwm_dac

Interface
REQ-001 SHALL have parameter SAMPLE_WIDTH, default 9, giving the sample width in bits and a PWM period of 2^SAMPLE_WIDTH clocks.
REQ-002 SHALL have port i_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port i_sample, input, SAMPLE_WIDTH bits: unsigned duty value (channel output level).
REQ-005 SHALL have port i_sample_valid, input, 1 bit: i_sample is offered this cycle.
REQ-006 SHALL have port o_sample_ready, output, 1 bit: the holding register can accept a sample.
REQ-007 SHALL have port o_pwm, output, 1 bit: registered PWM bitstream to the external RC filter.
REQ-008 SHALL have port o_period_stb, output, 1 bit: one-cycle pulse on the first cycle of each PWM period.
REQ-009 SHALL have port o_underrun, output, 1 bit: one-cycle pulse when a period starts with no new sample held.

Function
REQ-010 SHALL keep a free-running period counter of SAMPLE_WIDTH bits that increments every cycle and wraps from 2^SAMPLE_WIDTH-1 to 0.
REQ-011 SHALL keep a one-entry holding register plus a full flag; o_sample_ready SHALL equal the inverse of that flag, driven from a register with no combinational path from i_sample_valid.
REQ-012 SHALL accept a sample when i_sample_valid and o_sample_ready are both high, storing i_sample and setting the full flag on that edge.
REQ-013 SHALL, on the edge where the counter wraps to 0, copy the holding register into the active duty register and clear the full flag if the flag is set.
REQ-014 SHALL, on that wrap edge with the flag clear, retain the previous active duty and pulse o_underrun high for the first cycle of the new period.
REQ-015 SHALL treat an acceptance on the same edge as a wrap with an empty holding register as an underrun: the new sample lands in the holding register and loads at the next wrap.
REQ-016 SHALL drive o_pwm, registered, to the result of (counter < active duty), so o_pwm lags the compare by one clock.
REQ-017 SHALL give duty 0 an o_pwm that is constantly low and duty 2^SAMPLE_WIDTH-1 an o_pwm that is high for 2^SAMPLE_WIDTH-1 of the 2^SAMPLE_WIDTH cycles in the period.
REQ-018 SHALL assert o_period_stb in exactly the cycle where the counter equals 0.
REQ-019 SHALL ignore i_sample whenever i_sample_valid is low or o_sample_ready is low; no sample is overwritten or dropped once accepted.

Reset
REQ-020 SHALL, while i_rst_n is low, asynchronously force these values: counter 0, active duty 0, holding register 0, full flag 0, o_pwm 0, o_underrun 0.
REQ-021 SHALL, while i_rst_n is low, asynchronously force o_period_stb 0 and o_sample_ready 0; o_sample_ready SHALL rise on the first clock after release.
REQ-022 SHALL, on reset mid-period, discard the held and active samples; the first period after release SHALL start with counter 0 and raise o_underrun unless a sample was accepted before the first wrap.

Structure
REQ-023 SHALL take SAMPLE_WIDTH's default from constant AUDIO_SAMPLE_WIDTH in the shared package apu_audio_pkg, which is shared with the channel blocks.
REQ-024 SHALL place the counter and compare in one sub-module, pwm_counter, which emits the period-start and o_pwm terms; the handshake and holding logic SHALL stay in the top module.

Verification
REQ-025 SHALL cover: reset released, no samples -> o_underrun pulses every 512 cycles, o_pwm stays 0, and o_period_stb pulses every 512 cycles.
REQ-026 SHALL cover: sample 128 accepted before the first wrap -> in the next period o_pwm is high for exactly 128 cycles, starting one cycle after o_period_stb.
REQ-027 SHALL cover: samples 0 and then 511 -> o_pwm is 0 for the whole first period and high for 511 of 512 cycles in the second.
REQ-028 SHALL cover: i_sample_valid held high with values 5 and then 9 -> o_sample_ready drops after 5 is accepted, 9 is held off until the wrap, and 5 and 9 play in consecutive periods.
REQ-029 SHALL cover: acceptance on the exact wrap edge with the holder empty -> o_underrun pulses, the old duty repeats, and the new sample plays in the following period.
REQ-030 SHALL cover: i_rst_n asserted mid-period with duty 300 -> o_pwm drops to 0 immediately and the counter restarts at 0 after release.
